// File: rtl/avalon_pkg.sv
// Shared Avalon-ST definitions: the packet FSM state encoding and the pointer width helper.
package avalon_pkg;

  typedef enum logic [1:0] {
    IDLE_S    = 2'd0,
    LOADING_S = 2'd1,
    SENDING_S = 2'd2
  } state_t;

  // Pointers must be able to hold the full packet length, not just the last index.
  function automatic int PTR_W(input int max_len);
    return $clog2(max_len + 1);
  endfunction

endpackage

// File: rtl/pkt_buf.sv
// Packet word store: one synchronous write port, one asynchronous read port, no reset.
module pkt_buf #(
  parameter int DWIDTH = 10,
  parameter int DEPTH  = 10,
  parameter int AW     = 4
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DWIDTH-1:0] rdata_o
);

  logic [DWIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/avalon_pkt_tx.sv
// Avalon-ST packet transmitter: buffers one packet from the load port, then replays it
// with sop/eop framing under ready backpressure.
module avalon_pkt_tx
  import avalon_pkg::*;
#(
  parameter int DWIDTH      = 10,
  parameter int MAX_PKT_LEN = 10
) (
  input  logic              clk_i,
  input  logic              arst_n_i,
  input  logic [DWIDTH-1:0] ld_data_i,
  input  logic              ld_valid_i,
  input  logic              ld_last_i,
  output logic              ld_ready_o,
  output logic [DWIDTH-1:0] src_data_o,
  output logic              src_startofpacket_o,
  output logic              src_endofpacket_o,
  output logic              src_valid_o,
  input  logic              src_ready_i,
  output logic              ovf_o
);

  localparam int PW = PTR_W(MAX_PKT_LEN);
  localparam logic [PW-1:0] LAST_IDX = PW'(MAX_PKT_LEN - 1);
  localparam logic [PW-1:0] MAX_LEN  = PW'(MAX_PKT_LEN);

  state_t            state_q, state_d;
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     len_q, len_d;
  logic              ovf_q, ovf_d;
  logic              ld_ready_q, ld_ready_d;
  logic              src_valid_q, src_valid_d;
  logic              buf_we;
  logic              ld_acc;
  logic              src_xfer;
  logic              at_eop;
  logic [DWIDTH-1:0] rd_data;

  pkt_buf #(
    .DWIDTH(DWIDTH),
    .DEPTH (MAX_PKT_LEN),
    .AW    (PW)
  ) u_buf (
    .clk_i  (clk_i),
    .we_i   (buf_we),
    .waddr_i(wr_ptr_q),
    .wdata_i(ld_data_i),
    .raddr_i(rd_ptr_q),
    .rdata_o(rd_data)
  );

  assign ld_acc   = ld_valid_i & ld_ready_q;
  assign src_xfer = src_valid_q & src_ready_i;
  assign at_eop   = (rd_ptr_q == len_q - PW'(1));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    len_d    = len_q;
    ovf_d    = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      IDLE_S: begin
        if (ld_acc) begin
          buf_we   = 1'b1;
          wr_ptr_d = PW'(1);
          if (ld_last_i || (MAX_PKT_LEN == 1)) begin
            len_d   = PW'(1);
            state_d = SENDING_S;
          end else begin
            state_d = LOADING_S;
          end
        end
      end
      LOADING_S: begin
        if (ld_acc) begin
          buf_we   = 1'b1;
          wr_ptr_d = wr_ptr_q + PW'(1);
          if (ld_last_i) begin
            len_d   = wr_ptr_q + PW'(1);
            state_d = SENDING_S;
          end else if (wr_ptr_q == LAST_IDX) begin
            // Buffer full without a last word: cut the packet here and flag it.
            len_d   = MAX_LEN;
            ovf_d   = 1'b1;
            state_d = SENDING_S;
          end
        end
      end
      SENDING_S: begin
        if (src_xfer) begin
          if (at_eop) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            state_d  = IDLE_S;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      default: state_d = IDLE_S;
    endcase
  end

  // Handshake outputs are registered from the next state so nothing combinational reaches a port.
  assign ld_ready_d  = (state_d != SENDING_S);
  assign src_valid_d = (state_d == SENDING_S);

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      state_q     <= IDLE_S;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      len_q       <= '0;
      ovf_q       <= 1'b0;
      ld_ready_q  <= 1'b0;
      src_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      len_q       <= len_d;
      ovf_q       <= ovf_d;
      ld_ready_q  <= ld_ready_d;
      src_valid_q <= src_valid_d;
    end
  end

  assign ld_ready_o          = ld_ready_q;
  assign src_valid_o         = src_valid_q;
  assign src_data_o          = src_valid_q ? rd_data : '0;
  assign src_startofpacket_o = src_valid_q & (rd_ptr_q == '0);
  assign src_endofpacket_o   = src_valid_q & at_eop;
  assign ovf_o               = ovf_q;

endmodule

// File: tb/tb_avalon_pkt_tx.sv
// Self-checking bench for avalon_pkt_tx: queue-based packet model plus literal spot checks.
module tb_avalon_pkt_tx;

  localparam int DW   = 10;
  localparam int MAXL = 10;

  logic          clk = 1'b0;
  logic          arst_n = 1'b0;
  logic [DW-1:0] ld_data = '0;
  logic          ld_valid = 1'b0;
  logic          ld_last = 1'b0;
  logic          ld_ready_o;
  logic [DW-1:0] src_data_o;
  logic          src_sop_o;
  logic          src_eop_o;
  logic          src_valid_o;
  logic          src_ready = 1'b0;
  logic          ovf_o;

  always #5 clk = ~clk;

  avalon_pkt_tx #(.DWIDTH(DW), .MAX_PKT_LEN(MAXL)) dut (
    .clk_i              (clk),
    .arst_n_i           (arst_n),
    .ld_data_i          (ld_data),
    .ld_valid_i         (ld_valid),
    .ld_last_i          (ld_last),
    .ld_ready_o         (ld_ready_o),
    .src_data_o         (src_data_o),
    .src_startofpacket_o(src_sop_o),
    .src_endofpacket_o  (src_eop_o),
    .src_valid_o        (src_valid_o),
    .src_ready_i        (src_ready),
    .ovf_o              (ovf_o)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: words collect into a packet; a finished packet becomes a queue of beats.
  typedef struct packed {
    logic [DW-1:0] d;
    logic          sop;
    logic          eop;
  } beat_t;

  beat_t         out_q[$];
  logic [DW-1:0] cur_q[$];
  bit            mdl_ready = 1'b0;
  bit            mdl_ovf   = 1'b0;
  bit            trunc;
  bit            stalled   = 1'b0;
  logic [DW+2:0] prev_out;
  int            dut_xfers = 0;
  logic [DW+1:0] log_q[$];

  always @(negedge arst_n) begin
    out_q.delete();
    cur_q.delete();
    mdl_ready = 1'b0;
    mdl_ovf   = 1'b0;
    stalled   = 1'b0;
  end

  always @(posedge clk) begin
    if (arst_n) begin
      trunc   = 1'b0;
      stalled = src_valid_o && !src_ready;
      if (src_valid_o && src_ready) begin
        dut_xfers++;
        log_q.push_back({src_eop_o, src_sop_o, src_data_o});
      end
      if (out_q.size() > 0) begin
        if (src_ready) void'(out_q.pop_front());
      end else if (mdl_ready && ld_valid) begin
        cur_q.push_back(ld_data);
        if (ld_last || cur_q.size() == MAXL) begin
          trunc = !ld_last;
          for (int i = 0; i < cur_q.size(); i++)
            out_q.push_back('{d: cur_q[i], sop: (i == 0), eop: (i == cur_q.size() - 1)});
          cur_q.delete();
        end
      end
      mdl_ovf   = trunc;
      mdl_ready = (out_q.size() == 0);
    end
  end

  always @(negedge clk) begin
    if (!arst_n) begin
      chk("rst_valid", src_valid_o, 0);
      chk("rst_ld_ready", ld_ready_o, 0);
      chk("rst_data", src_data_o, 0);
      chk("rst_sop_eop", {src_sop_o, src_eop_o}, 0);
      chk("rst_ovf", ovf_o, 0);
    end else begin
      chk("ld_ready", ld_ready_o, mdl_ready);
      chk("src_valid", src_valid_o, out_q.size() > 0);
      chk("ovf", ovf_o, mdl_ovf);
      if (out_q.size() > 0) begin
        chk("src_data", src_data_o, out_q[0].d);
        chk("src_sop", src_sop_o, out_q[0].sop);
        chk("src_eop", src_eop_o, out_q[0].eop);
      end
      if (stalled)
        chk("stall_stable", {src_valid_o, src_sop_o, src_eop_o, src_data_o}, prev_out);
      prev_out = {src_valid_o, src_sop_o, src_eop_o, src_data_o};
    end
  end

  // Ready pattern: 0 always, 1 toggle, 2 random, 3 held low.
  int rdy_mode = 0;
  initial forever begin
    @(posedge clk);
    #1;
    case (rdy_mode)
      0: src_ready = 1'b1;
      1: src_ready = ~src_ready;
      2: src_ready = 1'($urandom_range(0, 1));
      default: src_ready = 1'b0;
    endcase
  end

  task automatic load_word(input logic [DW-1:0] d, input logic last);
    bit ok, acc;
    ld_data  = d;
    ld_last  = last;
    ld_valid = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 300 && !ok; k++) begin
      @(negedge clk);
      acc = ld_ready_o;
      @(posedge clk);
      #1;
      ok = acc;
    end
    if (!ok) chk("load_timeout", 0, 1);
    ld_valid = 1'b0;
    ld_last  = 1'b0;
  endtask

  task automatic wait_idle();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(negedge clk);
      done = ld_ready_o && !src_valid_o;
    end
    if (!done) chk("idle_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, len;
    logic [DW-1:0] a_pkt[4];
    logic [DW-1:0] b_pkt[2];

    repeat (3) @(posedge clk);
    #2 arst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ld_ready", ld_ready_o, 0);
    @(posedge clk);
    #1;

    // 1: 3,1,2 with ready held high
    rdy_mode = 0;
    wait_idle();
    base = dut_xfers;
    load_word(10'd3, 1'b0);
    load_word(10'd1, 1'b0);
    load_word(10'd2, 1'b1);
    @(negedge clk);
    chk("t1_beat0", {src_valid_o, src_sop_o, src_eop_o, src_data_o}, {3'b110, 10'd3});
    @(negedge clk);
    chk("t1_beat1", {src_valid_o, src_sop_o, src_eop_o, src_data_o}, {3'b100, 10'd1});
    @(negedge clk);
    chk("t1_beat2", {src_valid_o, src_sop_o, src_eop_o, src_data_o}, {3'b101, 10'd2});
    @(negedge clk);
    chk("t1_ld_ready_back", {ld_ready_o, src_valid_o}, 2'b10);
    @(posedge clk);
    #1;
    chk("t1_xfers", dut_xfers - base, 3);

    // 2: same packet, ready toggling
    rdy_mode = 1;
    load_word(10'd3, 1'b0);
    load_word(10'd1, 1'b0);
    load_word(10'd2, 1'b1);
    wait_idle();
    chk("t2_seq0", log_q[log_q.size()-3], 12'h403);
    chk("t2_seq1", log_q[log_q.size()-2], 12'h001);
    chk("t2_seq2", log_q[log_q.size()-1], 12'h802);

    // 3: single-word packet
    rdy_mode = 0;
    wait_idle();
    load_word(10'h2A, 1'b1);
    @(negedge clk);
    chk("t3_single", {src_valid_o, src_sop_o, src_eop_o, src_data_o}, {3'b111, 10'h2A});
    wait_idle();

    // 4: 12 words without last, overflow at 10
    rdy_mode = 3;
    @(posedge clk);
    #1;
    base = dut_xfers;
    for (int i = 0; i < MAXL; i++) load_word(DW'(100 + i), 1'b0);
    ld_valid = 1'b1;
    ld_data  = 10'd110;
    @(negedge clk);
    chk("t4_ovf_pulse", ovf_o, 1);
    chk("t4_ld_ready_w11", ld_ready_o, 0);
    @(posedge clk);
    #1;
    ld_data = 10'd111;
    @(negedge clk);
    chk("t4_ovf_single", ovf_o, 0);
    chk("t4_ld_ready_w12", ld_ready_o, 0);
    @(posedge clk);
    #1;
    ld_valid = 1'b0;
    rdy_mode = 0;
    wait_idle();
    chk("t4_xfers", dut_xfers - base, 10);
    chk("t4_last_beat", log_q[log_q.size()-1], {2'b10, 10'd109});

    // 5: reset on the second send beat, then a fresh 2-word packet
    load_word(10'd7, 1'b0);
    load_word(10'd8, 1'b0);
    load_word(10'd9, 1'b1);
    @(posedge clk);
    #1;
    arst_n = 1'b0;
    #1;
    chk("t5_valid_drop", src_valid_o, 0);
    repeat (2) @(posedge clk);
    #2 arst_n = 1'b1;
    @(posedge clk);
    #1;
    load_word(10'd5, 1'b0);
    load_word(10'd6, 1'b1);
    @(negedge clk);
    chk("t5_new_sop", {src_valid_o, src_sop_o, src_data_o}, {2'b11, 10'd5});
    wait_idle();

    // 6: back-to-back packets under random backpressure
    rdy_mode = 2;
    base = dut_xfers;
    foreach (a_pkt[i]) a_pkt[i] = DW'($urandom);
    foreach (b_pkt[i]) b_pkt[i] = DW'($urandom);
    foreach (a_pkt[i]) load_word(a_pkt[i], i == 3);
    foreach (b_pkt[i]) load_word(b_pkt[i], i == 1);
    wait_idle();
    chk("t6_xfers", dut_xfers - base, 6);
    for (int i = 0; i < 4; i++)
      chk("t6_a_beat", log_q[log_q.size()-6+i], {i == 3, i == 0, a_pkt[i]});
    for (int i = 0; i < 2; i++)
      chk("t6_b_beat", log_q[log_q.size()-2+i], {i == 1, i == 0, b_pkt[i]});

    // Randomized packets, lengths past the buffer included
    for (int p = 0; p < 40; p++) begin
      len = $urandom_range(1, 13);
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          @(posedge clk);
          #1;
        end
        load_word(DW'($urandom), i == len - 1);
      end
    end
    wait_idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
